// File: rtl/sar_adc_controller_pkg.sv
// Shared definitions for the SAR conversion controller and its analog-model neighbours.
package sar_pkg;

  localparam int unsigned N_BITS_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_HOLD   = 3'd2,
    S_TRIAL  = 3'd3,
    S_DONE   = 3'd4
  } sar_state_e;

  // hold_ctrl encoding, also understood by sample_and_hold
  localparam logic HC_TRACK = 1'b0;
  localparam logic HC_HOLD  = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_cycle_timer.sv
// Loadable down-counter with a zero flag; times the sample and settle intervals.
module sar_cycle_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sar_adc_controller.sv
// SAR conversion sequencer: track/hold control, MSB-first trial codes, bit resolution
// from the comparator, with valid/ready start and result handshakes plus abort.
module sar_adc_controller
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS        = N_BITS_DEFAULT,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              abort,
  output logic              hold_ctrl,
  output logic [N_BITS-1:0] dac_code,
  input  logic              cmp_in,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [N_BITS-1:0] result_data
);

  localparam int unsigned TW = $clog2(max_u(SAMPLE_CYCLES, SETTLE_CYCLES)) + 1;
  localparam int unsigned IW = max_u($clog2(N_BITS), 1);

  localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB     = IW'(N_BITS - 1);

  sar_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_BITS-1:0] result_q, result_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_zero;

  sar_cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_valid && !abort) begin
          tmr_load = 1'b1;
          tmr_val  = SAMPLE_LOAD;
          result_d = '0;
          state_d  = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (tmr_zero) state_d = S_HOLD;
        else          tmr_en  = 1'b1;
      end
      S_HOLD: begin
        idx_d    = IDX_MSB;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
        state_d  = S_TRIAL;
      end
      S_TRIAL: begin
        if (tmr_zero) begin
          result_d[idx_q] = cmp_in;
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q - 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition above and discards the partial/pending result
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = '0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  always_comb begin
    hold_ctrl = HC_HOLD;
    dac_code  = '0;
    unique case (state_q)
      S_IDLE, S_SAMPLE: hold_ctrl = HC_TRACK;
      S_TRIAL:          dac_code  = result_q | (N_BITS'(1) << idx_q);
      S_DONE:           dac_code  = result_q;
      default:          ;
    endcase
  end

  assign start_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result_data  = result_q;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller with ideal comparator models on two parameterisations.
module tb_sar_adc_controller;

  logic       clk;
  logic       rst_n;
  logic       start_valid, abort, result_ready;
  logic       start_ready, hold_ctrl, busy, result_valid, cmp_in;
  logic [9:0] dac_code, result_data;
  int         vin;

  logic       start_valid_b;
  logic       start_ready_b, hold_ctrl_b, busy_b, result_valid_b, cmp_in_b;
  logic [9:0] dac_code_b, result_data_b;
  int         vin_b;

  int errors = 0;
  int checks = 0;
  int seen [10];

  sar_adc_controller #(
    .N_BITS        (10),
    .SAMPLE_CYCLES (4),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .abort        (abort),
    .hold_ctrl    (hold_ctrl),
    .dac_code     (dac_code),
    .cmp_in       (cmp_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  sar_adc_controller #(
    .N_BITS        (10),
    .SAMPLE_CYCLES (1),
    .SETTLE_CYCLES (3)
  ) dut_b (
    .clk          (clk),
    .reset        (rst_n),
    .start_valid  (start_valid_b),
    .start_ready  (start_ready_b),
    .abort        (1'b0),
    .hold_ctrl    (hold_ctrl_b),
    .dac_code     (dac_code_b),
    .cmp_in       (cmp_in_b),
    .busy         (busy_b),
    .result_valid (result_valid_b),
    .result_ready (1'b1),
    .result_data  (result_data_b)
  );

  assign cmp_in   = (vin >= int'(dac_code));
  assign cmp_in_b = (vin_b >= int'(dac_code_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one conversion from IDLE; leaves the DUT in DONE, observed after the 15th edge.
  task automatic conv_a(input int v, input int exp_res, input string tag);
    int bad;
    bad = 0;
    vin = v;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (hold_ctrl !== ((k >= 4) ? 1'b1 : 1'b0)) bad++;
      if (result_valid !== 1'b0) bad++;
      if (busy !== 1'b1) bad++;
      if (k >= 5) seen[k-5] = int'(dac_code);
      if (k < 14) tick();
    end
    tick();
    chk({tag, "_timing"}, bad, 0);
    chk({tag, "_valid_at_15"}, result_valid, 1);
    chk({tag, "_data"}, result_data, exp_res);
    chk({tag, "_done_dac"}, dac_code, exp_res);
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, "_idle_valid"}, result_valid, 0);
    chk({tag, "_idle_ready"}, start_ready, 1);
    chk({tag, "_idle_hold"}, hold_ctrl, 0);
  endtask

  initial begin
    int exp600 [10];
    int bad, changes, first;
    exp600 = '{512, 768, 640, 576, 608, 592, 600, 604, 602, 601};

    rst_n = 1'b0;
    start_valid = 1'b0;
    abort = 1'b0;
    result_ready = 1'b0;
    start_valid_b = 1'b0;
    vin = 0;
    vin_b = 0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_hold", hold_ctrl, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_data", result_data, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_start_ready", start_ready, 1);

    conv_a(600, 600, "v600");
    for (int i = 0; i < 10; i++) chk("v600_trial_code", seen[i], exp600[i]);
    handshake("v600");

    conv_a(0, 0, "v0");
    handshake("v0");

    // back-to-back start directly after the handshake cycle
    conv_a(1023, 1023, "v1023");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      tick();
      if (result_valid !== 1'b1 || result_data !== 10'd1023 || start_ready !== 1'b0
          || hold_ctrl !== 1'b1) bad++;
    end
    start_valid = 1'b0;
    chk("backpressure_stable", bad, 0);
    handshake("v1023");

    // abort while resolving bit 5
    vin = 600;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_idx5_dac", dac_code, 608);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hold", hold_ctrl, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_dac", dac_code, 0);

    // abort beats result_ready in DONE
    conv_a(500, 500, "v500");
    abort = 1'b1;
    result_ready = 1'b1;
    tick();
    abort = 1'b0;
    result_ready = 1'b0;
    chk("abort_done_valid", result_valid, 0);
    chk("abort_done_busy", busy, 0);

    // abort in IDLE blocks a simultaneous start
    start_valid = 1'b1;
    abort = 1'b1;
    tick();
    start_valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_no_start", busy, 0);

    // asynchronous reset mid-SAMPLE
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    chk("pre_rst_sample_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sample_busy", busy, 0);
    chk("rst_sample_hold", hold_ctrl, 0);
    #3 rst_n = 1'b1;
    tick();

    // asynchronous reset mid-TRIAL with a partial result of 512
    vin = 600;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_trial_data", result_data, 512);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trial_busy", busy, 0);
    chk("rst_trial_hold", hold_ctrl, 0);
    chk("rst_trial_dac", dac_code, 0);
    chk("rst_trial_data", result_data, 0);
    chk("rst_trial_valid", result_valid, 0);
    #3 rst_n = 1'b1;
    tick();
    conv_a(341, 341, "v341");
    handshake("v341");

    // SAMPLE_CYCLES=1, SETTLE_CYCLES=3: SAMPLE k=0, HOLD k=1, TRIAL k=2..31, DONE k=32
    vin_b = 777;
    start_valid_b = 1'b1;
    tick();
    start_valid_b = 1'b0;
    bad = 0;
    changes = 0;
    first = 0;
    for (int k = 0; k < 32; k++) begin
      if (result_valid_b !== 1'b0) bad++;
      if (hold_ctrl_b !== ((k >= 1) ? 1'b1 : 1'b0)) bad++;
      if (k == 2) first = int'(dac_code_b);
      if (k > 2) begin
        if (((k - 2) % 3) == 0) begin
          if (dac_code_b !== seen[0][9:0]) changes++;
        end else if (dac_code_b !== seen[0][9:0]) begin
          bad++;
        end
      end
      seen[0] = int'(dac_code_b);
      if (k < 31) tick();
    end
    tick();
    chk("b_timing", bad, 0);
    chk("b_first_trial", first, 512);
    chk("b_code_changes", changes, 9);
    chk("b_valid_at_32", result_valid_b, 1);
    chk("b_data", result_data_b, 777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
